multisim_quasi_static_push_arbiter: RTL

Shares one push channel (valid/ready, toward a multisim push server) among NUM_CHANNELS quasi-static input signals. Each input is change-detected against a per-channel shadow register. The newest changed value is held pending, and a round-robin arbiter issues one tagged word at a time. It replaces N separate push servers when many slow-changing status signals cross to the remote simulator.

---
 rtl/multisim_quasi_static_push_arbiter_pkg.sv | 32 +++
 rtl/multisim_quasi_static_push_arbiter_if.sv | 16 +
 rtl/multisim_quasi_static_push_arbiter_rr_arbiter.sv | 31 +++
 rtl/multisim_quasi_static_push_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/multisim_quasi_static_push_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the quasi-static push arbiter.
package multisim_qs_pkg;

  typedef enum logic [0:0] {QS_IDLE, QS_SEND} qs_state_e;

  // Widest request vector rr_pick handles; callers zero-extend narrower ones.
  localparam int QS_MAX_CH = 32;

  // Round-robin search: start at ptr, ascend, wrap at n-1 -> 0.
  // Returns {found, idx}; idx is 0 when nothing is requested.
  function automatic logic [5:0] rr_pick(input logic [QS_MAX_CH-1:0] req,
                                         input logic [4:0] ptr,
                                         input int n);
    logic       found;
    logic [4:0] idx;
    int         c;
    found = 1'b0;
    idx   = 5'd0;
    for (int i = 0; i < QS_MAX_CH; i++) begin
      if (i < n && !found) begin
        c = int'(ptr) + i;
        if (c >= n) c = c - n;
        if (req[c]) begin
          found = 1'b1;
          idx   = c[4:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/multisim_quasi_static_push_arbiter_if.sv
// Push channel toward the multisim push server.
// Handshake: a word transfers on a posedge where out_vld && out_rdy are both 1.
// While out_vld is 1 the master keeps out_data/out_idx stable until the
// transfer; out_rdy may change freely and is ignored while out_vld is 0.
interface multisim_quasi_static_push_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 2
);
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_idx;

  modport master (output out_vld, output out_data, output out_idx, input out_rdy);
  modport slave  (input out_vld, input out_data, input out_idx, output out_rdy);
endinterface

// File: rtl/multisim_quasi_static_push_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: request vector + start pointer -> grant.
module multisim_rr_arbiter
  import multisim_qs_pkg::*;
#(
  parameter int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  logic [QS_MAX_CH-1:0] w_req_ext;
  logic [5:0]           w_pick;
  logic [4:0]           w_idx5;

  // Pick the first requester at or after the pointer and encode it both ways.
  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = i_req;
    w_pick           = rr_pick(w_req_ext, 5'(i_ptr), N);
    w_idx5           = w_pick[4:0];
    o_found          = w_pick[5];
    o_idx            = IW'(w_idx5);
    o_grant          = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = w_pick[5] && (w_idx5 == 5'(i));
    end
  end
endmodule

// File: rtl/multisim_quasi_static_push_arbiter.sv
// Shares one push channel among NUM_CHANNELS slow-changing inputs: each input
// is change-detected against a shadow copy, flagged pending, and issued one
// tagged word at a time in round-robin order.
module multisim_quasi_static_push_arbiter
  import multisim_qs_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int CNT_WIDTH    = 16,
  localparam int IDX_WIDTH   = $clog2(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
  multisim_quasi_static_push_arbiter_if.master push,
  output logic [NUM_CHANNELS-1:0]            pending,
  output logic [CNT_WIDTH-1:0]               coalesce_cnt,
  output qs_state_e                          dbg_state,
  output logic [IDX_WIDTH-1:0]               dbg_rr_ptr
);
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] r_shadow;
  logic [NUM_CHANNELS-1:0]                 r_pending;
  logic [CNT_WIDTH-1:0]                    r_cnt;
  logic [IDX_WIDTH-1:0]                    r_rr_ptr;
  qs_state_e                               r_state;
  qs_state_e                               w_state_nxt;
  logic                                    r_out_vld;
  logic [DATA_WIDTH-1:0]                   r_out_data;
  logic [IDX_WIDTH-1:0]                    r_out_idx;

  logic [NUM_CHANNELS-1:0] w_change;
  logic [NUM_CHANNELS-1:0] w_grant;
  logic [NUM_CHANNELS-1:0] w_clr;
  logic [NUM_CHANNELS-1:0] w_coal;
  logic [IDX_WIDTH-1:0]    w_win;
  logic [IDX_WIDTH-1:0]    w_ptr_nxt;
  logic                    w_found;
  logic                    w_issue;
  logic                    w_drop;
  logic [5:0]              w_coal_n;
  logic [CNT_WIDTH:0]      w_sum;
  logic [CNT_WIDTH-1:0]    w_cnt_nxt;

  multisim_rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .i_req   (r_pending),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_grant (w_grant),
    .o_idx   (w_win)
  );

  // A channel has changed when its sampled input differs from its shadow.
  always_comb begin
    w_change = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_change[k] = (data_in[k*DATA_WIDTH +: DATA_WIDTH] != r_shadow[k]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= QS_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: stay in SEND while words keep flowing back-to-back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      QS_IDLE: if (w_found) w_state_nxt = QS_SEND;
      QS_SEND: if (push.out_rdy && !w_found) w_state_nxt = QS_IDLE;
      default: w_state_nxt = QS_IDLE;
    endcase
  end

  // FSM outputs: load a new winner when the channel is free or just drained.
  always_comb begin
    w_issue = 1'b0;
    w_drop  = 1'b0;
    case (r_state)
      QS_IDLE: w_issue = w_found;
      QS_SEND: begin
        w_issue = push.out_rdy && w_found;
        w_drop  = push.out_rdy && !w_found;
      end
      default: ;
    endcase
  end

  // Pending clear, coalesce detection and saturating counter update.
  // A change on the channel being issued re-sets pending without counting.
  always_comb begin
    w_clr    = w_issue ? w_grant : '0;
    w_coal   = w_change & r_pending & ~w_clr;
    w_coal_n = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_coal_n = w_coal_n + 6'(w_coal[k]);
    end
    w_sum     = {1'b0, r_cnt} + (CNT_WIDTH+1)'(w_coal_n);
    w_cnt_nxt = w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
    w_ptr_nxt = (w_win == IDX_WIDTH'(NUM_CHANNELS-1)) ? '0 : w_win + IDX_WIDTH'(1);
  end

  // Datapath: shadows, pending flags, counter, pointer and the output word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_shadow[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
      r_pending  <= '1;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_idx  <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (w_change[k]) r_shadow[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
      r_pending <= (r_pending & ~w_clr) | w_change;
      r_cnt     <= w_cnt_nxt;
      if (w_issue) begin
        r_out_vld  <= 1'b1;
        r_out_data <= r_shadow[w_win];
        r_out_idx  <= w_win;
        r_rr_ptr   <= w_ptr_nxt;
      end else if (w_drop) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign push.out_vld  = r_out_vld;
  assign push.out_data = r_out_data;
  assign push.out_idx  = r_out_idx;
  assign pending       = r_pending;
  assign coalesce_cnt  = r_cnt;
  assign dbg_state     = r_state;
  assign dbg_rr_ptr    = r_rr_ptr;
endmodule
